// File: rtl/activate_diff_stage.sv
// Backprop error-term stage: delta[i] = dC/da[i] * f'(z[i]) in signed Q(data_size-8).8, one element per cycle.
// Optional macro ACT_DIFF_SAT_CNT_EN adds a saturating sat_count output.
module activate_diff_stage #(
    parameter int size                   = 3,
    parameter int data_size              = 16,
    parameter int cost_type_size         = 8,
    parameter int act_type_size          = 4,
    parameter int learning_rate_size     = 16,
    parameter int backprop_controll_size = 66
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [data_size*size-1:0]         predict_value,
    input  logic [data_size*size-1:0]         y,
    input  logic [data_size*size-1:0]         z,
    input  logic [data_size*size-1:0]         w,
    input  logic [data_size*size-1:0]         x,
    input  logic [act_type_size-1:0]          act_type,
    input  logic [cost_type_size-1:0]         cost_type,
    input  logic [learning_rate_size-1:0]     learning_rate,
    input  logic [backprop_controll_size-1:0] backprop_controll,
    output logic [data_size*size-1:0]         delta,
    output logic [data_size*size-1:0]         w_out,
    output logic [data_size*size-1:0]         x_out,
    output logic [learning_rate_size-1:0]     learning_rate_out,
    output logic [backprop_controll_size-1:0] backprop_controll_out,
`ifdef ACT_DIFF_SAT_CNT_EN
    output logic [15:0]                       sat_count,
`endif
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int CNT_W = (size > 1) ? $clog2(size) : 1;
    localparam int W     = data_size;

    localparam logic signed [W-1:0] D_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] D_MIN   = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] ONE     = W'(256);
    localparam logic signed [W-1:0] LEAK    = W'(16);
    localparam logic signed [W-1:0] HS_D    = W'(64);
    localparam logic signed [W-1:0] HS_LIM  = W'(512);
    localparam logic signed [W:0]   G_POS   = (W+1)'(256);
    localparam logic signed [W:0]   G_NEG   = -G_POS;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                     state;
    logic [CNT_W-1:0]           cnt;
    logic [W*size-1:0]          p_p0, y_p0, z_p0;
    logic [act_type_size-1:0]   act_p0;
    logic [cost_type_size-1:0]  cost_p0;

    logic signed [W-1:0]        p_e, y_e, z_e;
    logic signed [W:0]          g_raw;
    logic signed [W-1:0]        g, d;
    logic signed [2*W-1:0]      prod_full, prod_shr;
    logic signed [W-1:0]        prod_q;
    logic                       g_ovf, p_ovf;

    function automatic logic signed [W-1:0] sat_g(input logic signed [W:0] v);
        if (v[W] != v[W-1]) return v[W] ? D_MIN : D_MAX;
        return v[W-1:0];
    endfunction

    function automatic logic prod_overflow(input logic signed [2*W-1:0] v);
        return !((&v[2*W-1:W-1]) || !(|v[2*W-1:W-1]));
    endfunction

    function automatic logic signed [W-1:0] sat_prod(input logic signed [2*W-1:0] v);
        if (prod_overflow(v)) return v[2*W-1] ? D_MIN : D_MAX;
        return v[W-1:0];
    endfunction

    assign in_ready = (state == IDLE);

    // Element select: element 0 is the most significant slice
    always_comb begin
        p_e = '0;
        y_e = '0;
        z_e = '0;
        for (int i = 0; i < size; i++) begin
            if (cnt == CNT_W'(i)) begin
                p_e = $signed(p_p0[W*(size-i)-1 -: W]);
                y_e = $signed(y_p0[W*(size-i)-1 -: W]);
                z_e = $signed(z_p0[W*(size-i)-1 -: W]);
            end
        end
    end

    // Cost gradient at W+1 bits, then saturated
    always_comb begin
        g_raw = '0;
        if (cost_p0 == cost_type_size'(0)) begin
            g_raw = $signed({p_e[W-1], p_e}) - $signed({y_e[W-1], y_e});
        end else if (cost_p0 == cost_type_size'(1)) begin
            if (p_e > y_e)      g_raw = G_POS;
            else if (p_e < y_e) g_raw = G_NEG;
            else                g_raw = '0;
        end
        g_ovf = (g_raw[W] != g_raw[W-1]);
        g     = sat_g(g_raw);
    end

    // Activation derivative
    always_comb begin
        d = '0;
        if (act_p0 == act_type_size'(0)) begin
            d = ONE;
        end else if (act_p0 == act_type_size'(1)) begin
            d = (z_e > 0) ? ONE : '0;
        end else if (act_p0 == act_type_size'(2)) begin
            d = (z_e > 0) ? ONE : LEAK;
        end else if (act_p0 == act_type_size'(3)) begin
            d = ((z_e > -HS_LIM) && (z_e < HS_LIM)) ? HS_D : '0;
        end
    end

    // Product, Q8 realignment and saturation
    always_comb begin
        prod_full = $signed({{W{g[W-1]}}, g}) * $signed({{W{d[W-1]}}, d});
        prod_shr  = prod_full >>> 8;
        p_ovf     = prod_overflow(prod_shr);
        prod_q    = sat_prod(prod_shr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= IDLE;
            cnt                   <= '0;
            out_valid             <= 1'b0;
            p_p0                  <= '0;
            y_p0                  <= '0;
            z_p0                  <= '0;
            act_p0                <= '0;
            cost_p0               <= '0;
            delta                 <= '0;
            w_out                 <= '0;
            x_out                 <= '0;
            learning_rate_out     <= '0;
            backprop_controll_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        p_p0                  <= predict_value;
                        y_p0                  <= y;
                        z_p0                  <= z;
                        act_p0                <= act_type;
                        cost_p0               <= cost_type;
                        w_out                 <= w;
                        x_out                 <= x;
                        learning_rate_out     <= learning_rate;
                        backprop_controll_out <= backprop_controll;
                        delta                 <= '0;
                        cnt                   <= '0;
                        state                 <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int i = 0; i < size; i++) begin
                        if (cnt == CNT_W'(i)) delta[W*(size-i)-1 -: W] <= prod_q;
                    end
                    if (cnt == CNT_W'(size-1)) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACT_DIFF_SAT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if ((state == COMPUTE) && (g_ovf || p_ovf) && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_activate_diff_stage.sv
// Directed self-checking bench for activate_diff_stage (size=3, data_size=16).
module tb_activate_diff_stage;
    localparam int SZ = 3;
    localparam int DW = 16;
    localparam int BW = DW*SZ;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] predict_value = '0, y = '0, z = '0, w = '0, x = '0;
    logic [3:0]    act_type = '0;
    logic [7:0]    cost_type = '0;
    logic [15:0]   learning_rate = '0;
    logic [65:0]   backprop_controll = '0;
    logic [BW-1:0] delta, w_out, x_out;
    logic [15:0]   learning_rate_out;
    logic [65:0]   backprop_controll_out;
    logic          out_valid;
    logic          out_ready = 1'b0;
`ifdef ACT_DIFF_SAT_CNT_EN
    logic [15:0]   sat_count;
`endif

    int checks = 0;
    int failures = 0;

    activate_diff_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .predict_value(predict_value), .y(y), .z(z), .w(w), .x(x),
        .act_type(act_type), .cost_type(cost_type),
        .learning_rate(learning_rate), .backprop_controll(backprop_controll),
        .delta(delta), .w_out(w_out), .x_out(x_out),
        .learning_rate_out(learning_rate_out), .backprop_controll_out(backprop_controll_out),
`ifdef ACT_DIFF_SAT_CNT_EN
        .sat_count(sat_count),
`endif
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Drives one bundle (caller is in IDLE, #1 after an edge) and waits for out_valid.
    task automatic run_bundle(input logic [BW-1:0] p_i, y_i, z_i, input logic [3:0] a_i,
                              input logic [7:0] c_i, output int lat);
        predict_value = p_i; y = y_i; z = z_i; act_type = a_i; cost_type = c_i;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        checks++; if (delta !== '0) begin failures++; $display("FAIL reset_delta got=%h want=0", delta); end
        checks++; if (w_out !== '0 || backprop_controll_out !== '0) begin failures++; $display("FAIL reset_fwd got w=%h bc=%h want=0", w_out, backprop_controll_out); end
`ifdef ACT_DIFF_SAT_CNT_EN
        checks++; if (sat_count !== 16'h0) begin failures++; $display("FAIL reset_sat_count got=%h want=0", sat_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_relu_mse();
        int lat;
        w = {16'h1111, 16'h2222, 16'h3333};
        x = {16'hAAAA, 16'hBBBB, 16'hCCCC};
        learning_rate = 16'h0042;
        backprop_controll = 66'h2_DEAD_BEEF_0123_4567;
        run_bundle({16'h0100, 16'h0200, 16'hFF00}, {16'h0080, 16'h0200, 16'h0000},
                   {16'h0100, 16'hFF00, 16'h0080}, 4'd1, 8'd0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL relu_latency got=%0d want=3", lat); end
        checks++; if (delta !== {16'h0080, 16'h0000, 16'hFF00}) begin failures++; $display("FAIL relu_mse_delta got=%h want=0080_0000_ff00", delta); end
        checks++; if (w_out !== {16'h1111, 16'h2222, 16'h3333} || x_out !== {16'hAAAA, 16'hBBBB, 16'hCCCC}) begin
            failures++; $display("FAIL fwd_wx got w=%h x=%h", w_out, x_out); end
        checks++; if (learning_rate_out !== 16'h0042 || backprop_controll_out !== 66'h2_DEAD_BEEF_0123_4567) begin
            failures++; $display("FAIL fwd_lr_bc got lr=%h bc=%h", learning_rate_out, backprop_controll_out); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL done_in_ready got=%0b want=0", in_ready); end
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL release got ov=%0b ir=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_linear_sat();
        int lat;
`ifdef ACT_DIFF_SAT_CNT_EN
        logic [15:0] sc0;
        sc0 = sat_count;
`endif
        run_bundle({16'h7F00, 16'h0000, 16'h0000}, {16'h8100, 16'h0000, 16'h0000},
                   '0, 4'd0, 8'd0, lat);
        checks++; if (delta !== {16'h7FFF, 16'h0000, 16'h0000}) begin failures++; $display("FAIL linear_sat_delta got=%h want=7fff_0000_0000", delta); end
`ifdef ACT_DIFF_SAT_CNT_EN
        checks++; if (sat_count !== sc0 + 16'd1) begin failures++; $display("FAIL sat_count got=%h want=%h", sat_count, sc0 + 16'd1); end
`endif
        release_out();
    endtask

    task automatic test_leaky_hsig();
        int lat;
        run_bundle({16'h0100, 16'h0100, 16'h0100}, '0, {16'hFF00, 16'h0100, 16'h0000}, 4'd2, 8'd0, lat);
        checks++; if (delta !== {16'h0010, 16'h0100, 16'h0010}) begin failures++; $display("FAIL leaky_delta got=%h want=0010_0100_0010", delta); end
        release_out();
        run_bundle({16'h0100, 16'h0100, 16'h0100}, '0, {16'h0100, 16'h0300, 16'hFE00}, 4'd3, 8'd0, lat);
        checks++; if (delta !== {16'h0040, 16'h0000, 16'h0000}) begin failures++; $display("FAIL hsig_delta got=%h want=0040_0000_0000", delta); end
        release_out();
    endtask

    task automatic test_mae_other();
        int lat;
        run_bundle({16'h0010, 16'h0300, 16'h0050}, {16'h0020, 16'h0100, 16'h0050}, '0, 4'd0, 8'd1, lat);
        checks++; if (delta !== {16'hFF00, 16'h0100, 16'h0000}) begin failures++; $display("FAIL mae_delta got=%h want=ff00_0100_0000", delta); end
        release_out();
        run_bundle({16'h0300, 16'h0100, 16'h0200}, '0, {16'h0100, 16'h0100, 16'h0100}, 4'd0, 8'd5, lat);
        checks++; if (delta !== '0) begin failures++; $display("FAIL cost5_delta got=%h want=0", delta); end
        release_out();
        run_bundle({16'h0300, 16'h0100, 16'h0200}, '0, {16'h0100, 16'h0100, 16'h0100}, 4'd7, 8'd0, lat);
        checks++; if (delta !== '0) begin failures++; $display("FAIL act7_delta got=%h want=0", delta); end
        release_out();
    endtask

    task automatic test_stall();
        int lat;
        int bad = 0;
        w = {16'h0A0A, 16'h0B0B, 16'h0C0C};
        run_bundle({16'h0200, 16'h0000, 16'h0000}, {16'h0100, 16'h0000, 16'h0000}, '0, 4'd0, 8'd0, lat);
        predict_value = {16'h0400, 16'h0400, 16'h0400};
        w = {16'h5555, 16'h5555, 16'h5555};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                delta !== {16'h0100, 16'h0000, 16'h0000} || w_out !== {16'h0A0A, 16'h0B0B, 16'h0C0C}) bad++;
        end
        in_valid = 1'b0;
        checks++; if (bad !== 0) begin failures++; $display("FAIL stall_stable got bad_cycles=%0d want=0 (ov=%0b d=%h w=%h)", bad, out_valid, delta, w_out); end
        release_out();
        repeat (4) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL stall_no_capture got ov=%0b ir=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat;
        predict_value = {16'h0300, 16'h0300, 16'h0300}; y = '0; z = '0; act_type = 4'd0; cost_type = 8'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || delta !== '0) begin failures++; $display("FAIL mid_reset got ov=%0b d=%h want 0/0", out_valid, delta); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
        run_bundle({16'h0100, 16'h0200, 16'hFF00}, {16'h0080, 16'h0200, 16'h0000},
                   {16'h0100, 16'hFF00, 16'h0080}, 4'd1, 8'd0, lat);
        checks++; if (lat !== 3 || delta !== {16'h0080, 16'h0000, 16'hFF00}) begin
            failures++; $display("FAIL post_reset_bundle got lat=%0d d=%h want 3/0080_0000_ff00", lat, delta); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_relu_mse();
        test_linear_sat();
        test_leaky_hsig();
        test_mae_other();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
